// File: rtl/stage_execute_pkg.sv
// Shared execute-stage definitions: ALU opcodes, operand-select encodings and mult/div timing.
package stage_execute_pkg;

  localparam int ALU_OP_LEN = 5;
  typedef logic [ALU_OP_LEN-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD   = 5'd0;
  localparam alu_op_t ALU_OP_SUB   = 5'd1;
  localparam alu_op_t ALU_OP_SLL   = 5'd2;
  localparam alu_op_t ALU_OP_SRL   = 5'd3;
  localparam alu_op_t ALU_OP_SRA   = 5'd4;
  localparam alu_op_t ALU_OP_AND   = 5'd5;
  localparam alu_op_t ALU_OP_OR    = 5'd6;
  localparam alu_op_t ALU_OP_XOR   = 5'd7;
  localparam alu_op_t ALU_OP_NOR   = 5'd8;
  localparam alu_op_t ALU_OP_SLT   = 5'd9;
  localparam alu_op_t ALU_OP_SLTU  = 5'd10;
  localparam alu_op_t ALU_OP_MFHI  = 5'd11;
  localparam alu_op_t ALU_OP_MFLO  = 5'd12;
  localparam alu_op_t ALU_OP_MULT  = 5'd13;
  localparam alu_op_t ALU_OP_MULTU = 5'd14;
  localparam alu_op_t ALU_OP_DIV   = 5'd15;
  localparam alu_op_t ALU_OP_DIVU  = 5'd16;
  localparam alu_op_t ALU_OP_MTHI  = 5'd17;
  localparam alu_op_t ALU_OP_MTLO  = 5'd18;

  localparam logic ALU_SRC0_RS  = 1'b0;
  localparam logic ALU_SRC0_SA  = 1'b1;
  localparam logic ALU_SRC1_RT  = 1'b0;
  localparam logic ALU_SRC1_EXT = 1'b1;

  localparam int MD_CNT_LEN          = 4;
  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  function automatic logic is_muldiv(alu_op_t op);
    return (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) ||
           (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
  endfunction

endpackage

// File: rtl/stage_execute_muldiv.sv
// Multi-cycle mult/div unit: computes the result at start, holds it pending, and
// commits it to HI/LO when the countdown expires.
module muldiv_unit
  import stage_execute_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  alu_op_t     op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  logic [MD_CNT_LEN-1:0] cnt;
  logic [31:0]           pending_hi;
  logic [31:0]           pending_lo;
  logic                  pending_wr;

  logic [63:0]           prod_s;
  logic [63:0]           prod_u;
  logic [31:0]           div_s_den;
  logic [31:0]           div_u_den;
  logic [31:0]           quo_s;
  logic [31:0]           rem_s;
  logic [31:0]           quo_u;
  logic [31:0]           rem_u;
  logic                  div_ovf;
  logic [31:0]           next_hi;
  logic [31:0]           next_lo;
  logic                  next_wr;
  logic [MD_CNT_LEN-1:0] next_cnt;

  always_comb begin
    prod_s  = {{32{src0[31]}}, src0} * {{32{src1[31]}}, src1};
    prod_u  = {32'b0, src0} * {32'b0, src1};
    div_ovf = (src0 == 32'h8000_0000) && (src1 == 32'hFFFF_FFFF);
    // Divisors are steered away from 0 and the signed-overflow case so the
    // dividers never see an undefined operation; those cases are patched below.
    div_s_den = ((src1 == 32'd0) || div_ovf) ? 32'd1 : src1;
    div_u_den = (src1 == 32'd0) ? 32'd1 : src1;
    quo_s   = $signed(src0) / $signed(div_s_den);
    rem_s   = $signed(src0) % $signed(div_s_den);
    quo_u   = src0 / div_u_den;
    rem_u   = src0 % div_u_den;

    next_hi  = 32'd0;
    next_lo  = 32'd0;
    next_wr  = 1'b1;
    next_cnt = MD_CNT_LEN'(DIV_CYCLES);
    case (op)
      ALU_OP_MULT: begin
        {next_hi, next_lo} = prod_s;
        next_cnt = MD_CNT_LEN'(MULT_CYCLES);
      end
      ALU_OP_MULTU: begin
        {next_hi, next_lo} = prod_u;
        next_cnt = MD_CNT_LEN'(MULT_CYCLES);
      end
      ALU_OP_DIV: begin
        next_hi = div_ovf ? 32'd0 : rem_s;
        next_lo = div_ovf ? 32'h8000_0000 : quo_s;
        next_wr = (src1 != 32'd0);
      end
      ALU_OP_DIVU: begin
        next_hi = rem_u;
        next_lo = quo_u;
        next_wr = (src1 != 32'd0);
      end
      default: next_wr = 1'b0;
    endcase
  end

  // A new start overrides both a pending completion and any MTHI/MTLO in the
  // same edge; a completion overrides MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_wr <= 1'b0;
    end else begin
      if (mt_hi) hi <= mt_data;
      if (mt_lo) lo <= mt_data;
      if (start) begin
        cnt        <= next_cnt;
        pending_hi <= next_hi;
        pending_lo <= next_lo;
        pending_wr <= next_wr;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if ((cnt == MD_CNT_LEN'(1)) && pending_wr) begin
          hi <= pending_hi;
          lo <= pending_lo;
        end
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/stage_execute.sv
// Execute stage: operand select, combinational ALU with signed-overflow detect,
// and the HI/LO mult/div unit whose busy flag feeds the hazard unit.
module stage_execute
  import stage_execute_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        alu_src0,
  input  logic        alu_src1,
  input  alu_op_t     alu_op,
  input  logic [4:0]  sa,
  input  logic [31:0] ext_imm,
  input  logic        check_overflow,
  output logic [31:0] alu_result,
  output logic        overflow,
  output logic        md_start,
  output logic        md_busy
);

  // valid marks a real instruction held for exactly one cycle; there is no
  // back-pressure here, stalls are applied upstream using md_start/md_busy.
  logic [31:0] src0;
  logic [31:0] src1;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] hi;
  logic [31:0] lo;

  assign src0 = (alu_src0 == ALU_SRC0_SA) ? {27'b0, sa} : rs_data;
  assign src1 = (alu_src1 == ALU_SRC1_EXT) ? ext_imm : rt_data;
  assign sum  = src0 + src1;
  assign diff = src0 - src1;

  always_comb begin
    alu_result = 32'd0;
    overflow   = 1'b0;
    case (alu_op)
      ALU_OP_ADD: begin
        alu_result = sum;
        overflow   = check_overflow && (src0[31] == src1[31]) && (sum[31] != src0[31]);
      end
      ALU_OP_SUB: begin
        alu_result = diff;
        overflow   = check_overflow && (src0[31] != src1[31]) && (diff[31] != src0[31]);
      end
      ALU_OP_SLL:  alu_result = src1 << src0[4:0];
      ALU_OP_SRL:  alu_result = src1 >> src0[4:0];
      ALU_OP_SRA:  alu_result = 32'($signed(src1) >>> src0[4:0]);
      ALU_OP_AND:  alu_result = src0 & src1;
      ALU_OP_OR:   alu_result = src0 | src1;
      ALU_OP_XOR:  alu_result = src0 ^ src1;
      ALU_OP_NOR:  alu_result = ~(src0 | src1);
      ALU_OP_SLT:  alu_result = {31'b0, $signed(src0) < $signed(src1)};
      ALU_OP_SLTU: alu_result = {31'b0, src0 < src1};
      ALU_OP_MFHI: alu_result = hi;
      ALU_OP_MFLO: alu_result = lo;
      default:     alu_result = 32'd0;
    endcase
  end

  assign md_start = valid && is_muldiv(alu_op);

  muldiv_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start   (md_start),
    .op      (alu_op),
    .src0    (src0),
    .src1    (src1),
    .mt_hi   (valid && (alu_op == ALU_OP_MTHI)),
    .mt_lo   (valid && (alu_op == ALU_OP_MTLO)),
    .mt_data (rs_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (md_busy)
  );

endmodule

// File: tb/tb_stage_execute.sv
// Bench for stage_execute: directed literal checks plus randomized traffic compared
// every cycle against a cycle-numbered behavioural model of the ALU and HI/LO.
module tb_stage_execute;
  import stage_execute_pkg::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] rs_data, rt_data, ext_imm;
  logic        alu_src0, alu_src1;
  alu_op_t     alu_op;
  logic [4:0]  sa;
  logic        check_overflow;
  logic [31:0] alu_result;
  logic        overflow, md_start, md_busy;

  stage_execute dut (
    .clk(clk), .reset(reset), .valid(valid), .rs_data(rs_data), .rt_data(rt_data),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op), .sa(sa),
    .ext_imm(ext_imm), .check_overflow(check_overflow), .alu_result(alu_result),
    .overflow(overflow), .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: HI/LO values plus the cycle numbers of the latest start and its completion.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  int          cyc = 0;
  int          start_c = -100;
  int          end_c = -100;
  logic [31:0] exp_result;
  logic        exp_ovf, exp_start, exp_busy;
  bit          cmp_en = 1'b0;

  task automatic chk32(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, req);
    end
  endtask

  task automatic chk1(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, req);
    end
  endtask

  function automatic bit op_is_md(alu_op_t op);
    return op inside {ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};
  endfunction

  function automatic logic [31:0] op_a();
    return alu_src0 ? {27'b0, sa} : rs_data;
  endfunction

  function automatic logic [31:0] op_b();
    return alu_src1 ? ext_imm : rt_data;
  endfunction

  task automatic model_comb();
    logic [31:0] a, b;
    longint as_, bs_, s;
    a = op_a();
    b = op_b();
    as_ = longint'($signed(a));
    bs_ = longint'($signed(b));
    exp_ovf = 1'b0;
    case (alu_op)
      ALU_OP_ADD: begin
        s = as_ + bs_;
        exp_result = 32'(s);
        exp_ovf = check_overflow && (s > MAX_S || s < MIN_S);
      end
      ALU_OP_SUB: begin
        s = as_ - bs_;
        exp_result = 32'(s);
        exp_ovf = check_overflow && (s > MAX_S || s < MIN_S);
      end
      ALU_OP_SLL:  exp_result = 32'(longint'(b) * (64'd1 << a[4:0]));
      ALU_OP_SRL:  exp_result = 32'(longint'(b) / (64'd1 << a[4:0]));
      ALU_OP_SRA:  exp_result = 32'(bs_ >>> a[4:0]);
      ALU_OP_AND:  exp_result = a & b;
      ALU_OP_OR:   exp_result = a | b;
      ALU_OP_XOR:  exp_result = a ^ b;
      ALU_OP_NOR:  exp_result = ~(a | b);
      ALU_OP_SLT:  exp_result = (as_ < bs_) ? 32'd1 : 32'd0;
      ALU_OP_SLTU: exp_result = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      ALU_OP_MFHI: exp_result = m_hi;
      ALU_OP_MFLO: exp_result = m_lo;
      default:     exp_result = 32'd0;
    endcase
    exp_start = valid && op_is_md(alu_op);
    exp_busy  = (cyc > start_c) && (cyc <= end_c);
  endtask

  task automatic model_edge();
    logic [31:0] a, b;
    longint as_, bs_, q, r, p;
    a = op_a();
    b = op_b();
    as_ = longint'($signed(a));
    bs_ = longint'($signed(b));
    if (reset) begin
      m_hi = 0; m_lo = 0; p_wr = 0; start_c = -100; end_c = -100;
    end else begin
      if (valid && alu_op == ALU_OP_MTHI) m_hi = rs_data;
      if (valid && alu_op == ALU_OP_MTLO) m_lo = rs_data;
      if (valid && op_is_md(alu_op)) begin
        start_c = cyc;
        p_wr = 1'b1;
        case (alu_op)
          ALU_OP_MULT:  begin p = as_ * bs_; {p_hi, p_lo} = p; end
          ALU_OP_MULTU: begin p = longint'(a) * longint'(b); {p_hi, p_lo} = p; end
          ALU_OP_DIV: begin
            p_wr = (b != 0);
            if (b != 0) begin q = as_ / bs_; r = as_ % bs_; p_lo = 32'(q); p_hi = 32'(r); end
          end
          default: begin
            p_wr = (b != 0);
            if (b != 0) begin
              q = longint'(a) / longint'(b); r = longint'(a) % longint'(b);
              p_lo = 32'(q); p_hi = 32'(r);
            end
          end
        endcase
        end_c = cyc + ((alu_op == ALU_OP_MULT || alu_op == ALU_OP_MULTU) ? N_MULT : N_DIV);
      end else if (cyc == end_c && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
    cyc++;
  endtask

  task automatic drive(bit v, alu_op_t op, logic [31:0] rs, logic [31:0] rt,
                       bit s0, bit s1, logic [4:0] sh, logic [31:0] imm, bit chk);
    valid = v; alu_op = op; rs_data = rs; rt_data = rt;
    alu_src0 = s0; alu_src1 = s1; sa = sh; ext_imm = imm; check_overflow = chk;
    model_comb();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rr(alu_op_t op, logic [31:0] rs, logic [31:0] rt);
    drive(1'b1, op, rs, rt, ALU_SRC0_RS, ALU_SRC1_RT, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic bubbles(int n, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, ALU_OP_ADD, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 1'b0);
      if (md_busy) busy_cnt++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk32("alu_result", alu_result, exp_result);
      chk1("overflow", overflow, exp_ovf);
      chk1("md_start", md_start, exp_start);
      chk1("md_busy", md_busy, exp_busy);
    end
  end

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    reset = 1'b1;
    drive(1'b0, ALU_OP_ADD, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    cmp_en = 1'b1;

    rr(ALU_OP_MFHI, 0, 0);
    chk32("reset_hi", alu_result, 32'd0);
    chk1("reset_busy", md_busy, 1'b0);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    chk32("reset_lo", alu_result, 32'd0);
    tick();

    drive(1'b1, ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 5'd0, 32'd0, 1'b1);
    chk32("add_wrap", alu_result, 32'h8000_0000);
    chk1("add_ovf", overflow, 1'b1);
    tick();
    drive(1'b1, ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 5'd0, 32'd0, 1'b0);
    chk1("add_noovf", overflow, 1'b0);
    tick();
    drive(1'b1, ALU_OP_SLL, 32'd0, 32'd0, ALU_SRC0_SA, ALU_SRC1_EXT, 5'd16, 32'h0000_1234, 1'b0);
    chk32("lui", alu_result, 32'h1234_0000);
    tick();
    drive(1'b1, ALU_OP_SRA, 32'd0, 32'h8000_0000, ALU_SRC0_SA, ALU_SRC1_RT, 5'd4, 32'd0, 1'b0);
    chk32("sra", alu_result, 32'hF800_0000);
    tick();
    rr(ALU_OP_SLTU, 32'd1, 32'hFFFF_FFFF);
    chk32("sltu", alu_result, 32'd1);
    tick();
    rr(ALU_OP_SLT, 32'd1, 32'hFFFF_FFFF);
    chk32("slt", alu_result, 32'd0);
    tick();

    rr(ALU_OP_MULT, 32'hFFFF_FFFF, 32'd2);
    chk1("mult_start", md_start, 1'b1);
    tick();
    bubbles(N_MULT, bc);
    chk32("mult_busy_cycles", 32'(bc), 32'd5);
    rr(ALU_OP_MFHI, 0, 0);
    chk1("mult_done", md_busy, 1'b0);
    chk32("mult_hi", alu_result, 32'hFFFF_FFFF);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    chk32("mult_lo", alu_result, 32'hFFFF_FFFE);
    tick();

    rr(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    bubbles(N_MULT, bc);
    rr(ALU_OP_MFHI, 0, 0);
    chk32("multu_hi", alu_result, 32'd1);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    chk32("multu_lo", alu_result, 32'hFFFF_FFFE);
    tick();

    rr(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    tick();
    bubbles(N_DIV, bc);
    chk32("div_busy_cycles", 32'(bc), 32'd10);
    rr(ALU_OP_MFLO, 0, 0);
    chk32("div_lo", alu_result, 32'hFFFF_FFFD);
    tick();
    rr(ALU_OP_MFHI, 0, 0);
    chk32("div_hi", alu_result, 32'hFFFF_FFFF);
    tick();

    rr(ALU_OP_DIVU, 32'd7, 32'd0);
    tick();
    bubbles(N_DIV, bc);
    rr(ALU_OP_MFHI, 0, 0);
    chk32("div0_hi", alu_result, 32'hFFFF_FFFF);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    chk32("div0_lo", alu_result, 32'hFFFF_FFFD);
    tick();

    rr(ALU_OP_MTHI, 32'hA5A5_A5A5, 0);
    tick();
    rr(ALU_OP_MFHI, 0, 0);
    chk32("mthi", alu_result, 32'hA5A5_A5A5);
    tick();

    rr(ALU_OP_DIV, 32'd100, 32'd7);
    tick();
    rr(ALU_OP_MTLO, 32'h0000_1111, 0);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    chk32("mtlo_pending", alu_result, 32'h0000_1111);
    tick();
    bubbles(N_DIV - 2, bc);
    rr(ALU_OP_MFLO, 0, 0);
    chk32("mtlo_overwritten", alu_result, 32'd14);
    tick();

    rr(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    bubbles(N_DIV, bc);
    rr(ALU_OP_MFLO, 0, 0);
    chk32("divovf_lo", alu_result, 32'h8000_0000);
    tick();
    rr(ALU_OP_MFHI, 0, 0);
    chk32("divovf_hi", alu_result, 32'd0);
    tick();

    rr(ALU_OP_DIV, 32'd9, 32'd2);
    tick();
    bubbles(2, bc);
    reset = 1'b1;
    drive(1'b0, ALU_OP_ADD, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 1'b0);
    tick();
    reset = 1'b0;
    rr(ALU_OP_MFHI, 0, 0);
    chk1("rst_abort_busy", md_busy, 1'b0);
    chk32("rst_abort_hi", alu_result, 32'd0);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    chk32("rst_abort_lo", alu_result, 32'd0);
    tick();
    bubbles(N_DIV, bc);
    chk32("rst_abort_nobusy", 32'(bc), 32'd0);
    rr(ALU_OP_MFLO, 0, 0);
    chk32("rst_abort_nowrite", alu_result, 32'd0);
    tick();

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), alu_op_t'($urandom_range(0, 21)), rnd32(), rnd32(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            rnd32(), 1'($urandom_range(0, 1)));
      tick();
    end
    bubbles(N_DIV + 1, bc);
    rr(ALU_OP_MFHI, 0, 0);
    tick();
    rr(ALU_OP_MFLO, 0, 0);
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
